// File: rtl/pc_flag_ctrl.sv
// -----------------------------------------------------------------------------
// pc_flag_ctrl
//
// Consumer end of the ALU flag interface in the single-cycle datapath. Latches
// the ALU Z/N/V outputs into the architectural FLAG register according to the
// retiring opcode, evaluates B/BR branch conditions against the stored flags,
// and owns the 16-bit PC (including PC+2 for PCS and the HLT halt state).
//
// Parameters:
//   RESET_PC      PC value loaded on reset
//
// Ports:
//   clk           system clock, all state updates on rising edge
//   rst_n         asynchronous active-low reset
//   en            instruction on opcode/ccc/imm9/rs_val retires this cycle
//   opcode        instruction opcode (0000 ADD ... 1111 HLT)
//   ccc           branch condition field
//   imm9          B offset, signed, counted in instructions
//   rs_val        register value used as BR target
//   alu_z/n/v     ALU flags for the current instruction
//   pc            current PC (fetch address), registered
//   pc_plus2      pc + 2 mod 2^16, combinational (PCS write data)
//   flag_z/n/v    stored flags, registered
//   branch_taken  combinational, current B/BR redirects the PC
//   halted        high while in the HALT state
// -----------------------------------------------------------------------------
module pc_flag_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [3:0]  opcode,
   input  logic [2:0]  ccc,
   input  logic [8:0]  imm9,
   input  logic [15:0] rs_val,
   input  logic        alu_z,
   input  logic        alu_n,
   input  logic        alu_v,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        flag_z,
   output logic        flag_n,
   output logic        flag_v,
   output logic        branch_taken,
   output logic        halted
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [15:0] pc_r;
   logic [15:0] pc_nxt_s;
   logic [15:0] pc_plus2_s;
   logic [15:0] b_target_s;
   logic        flag_z_r;
   logic        flag_n_r;
   logic        flag_v_r;
   logic        flag_z_nxt_s;
   logic        flag_n_nxt_s;
   logic        flag_v_nxt_s;
   logic        cond_s;
   logic        is_branch_s;
   logic        taken_s;

   // Branch condition against the stored flags; GE is written as Z | ~N,
   // which is the same set as Z=1 or (Z=0 and N=0).
   function automatic logic cond_eval(input logic [2:0] c,
                                      input logic z,
                                      input logic n,
                                      input logic v);
      logic r;
      case (c)
         3'b000:  r = ~z;
         3'b001:  r = z;
         3'b010:  r = ~z & ~n;
         3'b011:  r = n;
         3'b100:  r = z | ~n;
         3'b101:  r = n | z;
         3'b110:  r = v;
         3'b111:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Opcodes that write all three flags.
   function automatic logic writes_znv(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Opcodes that write Z only (N and V hold).
   function automatic logic writes_z_only(input logic [3:0] op);
      return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
   endfunction

   // Sequential successor and B target; both wrap modulo 2^16.
   always_comb begin
      pc_plus2_s = pc_r + 16'd2;
      b_target_s = pc_plus2_s + {{6{imm9[8]}}, imm9, 1'b0};
   end

   // Branch decision: only a retiring B/BR in RUN can redirect the PC.
   always_comb begin
      is_branch_s = (opcode == OP_B) || (opcode == OP_BR);
      cond_s      = cond_eval(ccc, flag_z_r, flag_n_r, flag_v_r);
      if ((state_r == ST_RUN) && en && is_branch_s) begin
         taken_s = cond_s;
      end else begin
         taken_s = 1'b0;
      end
   end

   // Next-state, next-PC and next-flag logic; everything holds unless a
   // retiring instruction in RUN says otherwise.
   always_comb begin
      state_nxt_s  = state_r;
      pc_nxt_s     = pc_r;
      flag_z_nxt_s = flag_z_r;
      flag_n_nxt_s = flag_n_r;
      flag_v_nxt_s = flag_v_r;
      case (state_r)
         ST_RUN: begin
            if (en) begin
               // Flag writes
               if (writes_znv(opcode)) begin
                  flag_z_nxt_s = alu_z;
                  flag_n_nxt_s = alu_n;
                  flag_v_nxt_s = alu_v;
               end else if (writes_z_only(opcode)) begin
                  flag_z_nxt_s = alu_z;
               end else begin
                  flag_z_nxt_s = flag_z_r;
               end
               // PC selection; HLT keeps the PC on the HLT address
               if (opcode == OP_HLT) begin
                  state_nxt_s = ST_HALT;
                  pc_nxt_s    = pc_r;
               end else if (taken_s && (opcode == OP_B)) begin
                  pc_nxt_s = b_target_s;
               end else if (taken_s && (opcode == OP_BR)) begin
                  pc_nxt_s = rs_val;
               end else begin
                  pc_nxt_s = pc_plus2_s;
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_HALT: begin
            state_nxt_s = ST_HALT;
         end
         default: begin
            state_nxt_s = ST_HALT;
         end
      endcase
   end

   // State, PC and FLAG registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_RUN;
         pc_r     <= RESET_PC;
         flag_z_r <= 1'b0;
         flag_n_r <= 1'b0;
         flag_v_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         pc_r     <= pc_nxt_s;
         flag_z_r <= flag_z_nxt_s;
         flag_n_r <= flag_n_nxt_s;
         flag_v_r <= flag_v_nxt_s;
      end
   end

   // Output mapping.
   always_comb begin
      pc           = pc_r;
      pc_plus2     = pc_plus2_s;
      flag_z       = flag_z_r;
      flag_n       = flag_n_r;
      flag_v       = flag_v_r;
      branch_taken = taken_s;
      halted       = (state_r == ST_HALT);
   end

endmodule

// File: doc/pc_flag_ctrl.md
Name: pc_flag_ctrl

Overview:
Consumer end of the ALU flag interface. Latches the ALU's Z/N/V outputs into the architectural FLAG register under per-opcode update rules. Evaluates B/BR conditions against the stored flags and owns the 16-bit PC register, including PC+2 for PCS and the HLT halt state. Sits between the decode stage and instruction fetch in the single-cycle datapath.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  instruction in opcode/ccc/imm9/rs_val retires this cycle
opcode  input  4  instruction opcode (0000 ADD … 1111 HLT)
ccc  input  3  branch condition field
imm9  input  9  B offset, signed, in instructions
rs_val  input  16  register value, BR target
alu_z  input  1  ALU zero flag for current instruction
alu_n  input  1  ALU negative flag for current instruction
alu_v  input  1  ALU overflow flag for current instruction
pc  output  16  current PC (fetch address)
pc_plus2  output  16  pc + 2 mod 2^16, combinational (PCS write data)
flag_z  output  1  stored Z
flag_n  output  1  stored N
flag_v  output  1  stored V
branch_taken  output  1  combinational; current B/BR redirects PC
halted  output  1  high in HALT state

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, flag_z=flag_n=flag_v=0, halted=0, state RUN. Reset mid-operation overrides any pending update immediately; no update on the first edge is lost or applied.
- FSM: RUN, HALT. RUN→HALT on rising edge with en=1 and opcode=1111. HALT exits only via reset. In HALT, pc, flags and halted hold; all inputs are ignored; branch_taken=0.
- Flag update (RUN, en=1, on edge):
  - ADD 0000 and SUB 0001 write Z, N, V.
  - XOR 0010, SLL 0100, SRA 0101 and ROR 0110 write Z only; N and V hold.
  - All other opcodes leave all flags unchanged.
- Condition uses the stored flags (from prior instructions), never the alu_* inputs of the same cycle:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- branch_taken = RUN & en & (opcode==1100 or 1101) & cond.
- Next PC (RUN, en=1, on edge):
  - B taken: pc_plus2 + (sext(imm9)<<1), mod 2^16.
  - BR taken: rs_val; bit 0 is passed unmodified.
  - HLT: pc holds, staying at the HLT address.
  - Otherwise: pc_plus2.
- en=0 in RUN: pc and flags hold; branch_taken=0.
- Wrap: pc=FFFE → 0000 on a sequential step; branch sums wrap silently with no error.
- A branch and a flag update never occur in the same instruction, so there is no ordering conflict.
- Latency: pc, flags and halted change one edge after the retiring instruction. branch_taken and pc_plus2 are same-cycle.

Test Plan:
- Reset then 3 cycles with en=1, opcode=0010, alu_z=0 → pc = 0000, 0002, 0004, 0006; flag_z=0; N and V remain 0.
- SUB with alu_z=1, alu_n=0, alu_v=1, then XOR with alu_z=0, alu_n=1 → flags after XOR: Z=0, N=0, V=1 (N and V held by XOR).
- Flags Z=1 at pc=0010: B ccc=001 imm9=1FE (-2) → branch_taken=1, next pc=000E. Same with ccc=000 → pc=0012, branch_taken=0.
- BR ccc=111 rs_val=ABCD → pc=ABCD. BR ccc=110 with V=0 → pc+2.
- pc=FFFE sequential → pc=0000. B imm9=0FF at pc=FF00 → pc=00FF+...: FF02+01FE=0100.
- HLT at pc=0020 → halted=1, pc=0020 thereafter despite en=1 ADD/B stimulus with flags frozen. Assert rst_n=0 asynchronously mid-cycle → immediate pc=0000, halted=0.
